// File: rtl/sprite_layer_ctrl.sv
// Game-over screen sequencer (PLAY/FLASH/HOLD) plus per-pixel layer arbitration
// for the VGA output. All state changes happen on frame boundaries.
module sprite_layer_ctrl #(
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 8,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  h_cnt_i,
  input  logic [9:0]  v_cnt_i,
  input  logic        valid_i,
  input  logic        game_over_i,
  input  logic        restart_i,
  input  logic        lose_on_i,
  input  logic [11:0] lose_pixel_i,
  input  logic        player_on_i,
  input  logic [11:0] player_pixel_i,
  input  logic        fungi_on_i,
  input  logic [11:0] fungi_pixel_i,
  input  logic [11:0] bg_pixel_i,
  output logic [11:0] rgb_o,
  output logic        lose_en_o,
  output logic [1:0]  state_o,
  output logic        frame_start_o
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [6:0] FLASH_LAST = 7'(FLASH_FRAMES - 1);
  localparam logic [6:0] BLINK_DIV  = 7'(BLINK_FRAMES);

  state_e      state_q, state_d;
  logic [6:0]  frame_cnt_q, frame_cnt_d;
  logic        go_pend_q, go_pend_d;
  logic        rs_pend_q, rs_pend_d;
  logic        frame_start_q, frame_start_d;
  logic        lose_on_q, player_on_q, fungi_on_q, valid_q;
  logic [11:0] rgb_q, rgb_d;
  logic [6:0]  blink_idx;
  logic        show_lose;

  assign frame_start_d = (h_cnt_i == 10'd0) && (v_cnt_i == 10'd0);

  // Pending flags are consumed on every frame_start; a pulse landing on that
  // same cycle is kept for the following frame.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    go_pend_d   = go_pend_q | game_over_i;
    rs_pend_d   = rs_pend_q | restart_i;
    if (frame_start_q) begin
      go_pend_d = game_over_i;
      rs_pend_d = restart_i;
      case (state_q)
        ST_PLAY: begin
          if (go_pend_q) begin
            state_d     = ST_FLASH;
            frame_cnt_d = 7'd0;
          end
        end
        ST_FLASH: begin
          if (frame_cnt_q == FLASH_LAST) state_d = ST_HOLD;
          else                           frame_cnt_d = frame_cnt_q + 7'd1;
        end
        ST_HOLD: begin
          if (rs_pend_q) state_d = ST_PLAY;
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  assign blink_idx = frame_cnt_q / BLINK_DIV;

  always_comb begin
    show_lose = 1'b0;
    case (state_q)
      ST_FLASH: show_lose = ~blink_idx[0];
      ST_HOLD:  show_lose = 1'b1;
      default:  show_lose = 1'b0;
    endcase
  end

  // Stage-2 mux: coverage flags are one cycle old, matching the ROM latency.
  always_comb begin
    rgb_d = 12'h000;
    if (valid_q) begin
      if (show_lose && lose_on_q && (lose_pixel_i != KEY_COLOR))
        rgb_d = lose_pixel_i;
      else if (player_on_q && (player_pixel_i != KEY_COLOR))
        rgb_d = player_pixel_i;
      else if (fungi_on_q && (fungi_pixel_i != KEY_COLOR))
        rgb_d = fungi_pixel_i;
      else
        rgb_d = bg_pixel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_PLAY;
      frame_cnt_q   <= 7'd0;
      go_pend_q     <= 1'b0;
      rs_pend_q     <= 1'b0;
      frame_start_q <= 1'b0;
      lose_on_q     <= 1'b0;
      player_on_q   <= 1'b0;
      fungi_on_q    <= 1'b0;
      valid_q       <= 1'b0;
      rgb_q         <= 12'h000;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      go_pend_q     <= go_pend_d;
      rs_pend_q     <= rs_pend_d;
      frame_start_q <= frame_start_d;
      lose_on_q     <= lose_on_i;
      player_on_q   <= player_on_i;
      fungi_on_q    <= fungi_on_i;
      valid_q       <= valid_i;
      rgb_q         <= rgb_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign lose_en_o     = (state_q != ST_PLAY);
  assign state_o       = state_q;
  assign frame_start_o = frame_start_q;

endmodule
